ervp_fifo_rd_packer: RTL and testbench



---
 rtl/ervp_fifo_rd_packer_if.sv | 42 ++++
 rtl/ervp_fifo_rd_packer.sv | 144 ++++++++++++++
 tb/tb_ervp_fifo_rd_packer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ervp_fifo_rd_packer_if.sv
// Purpose : bundles the FIFO read port, the packed output stream and the flush
//           handshake of ervp_fifo_rd_packer into one connection.
// Latency : none; wiring only.
// Backpressure: carried by out_ready (consumer) and fifo_rready (FIFO not empty).
//
// Signals:
//   fifo_rready   FIFO -> packer   FIFO holds data
//   fifo_rrequest packer -> FIFO   pop strobe (combinational)
//   fifo_rdata    FIFO -> packer   FIFO head word
//   out_valid     packer -> sink   packed word available
//   out_ready     sink -> packer   sink accepts the word
//   out_data      packer -> sink   packed word, lane i = [i*BW_DATA +: BW_DATA]
//   out_count     packer -> sink   number of valid lanes
//   flush         sink -> packer   request to emit a partial word
//   flush_busy    packer -> sink   flush pending
// Modports: master = packer side, slave = environment side.
interface ervp_fifo_rd_packer_if #(
    parameter int BW_DATA = 8,
    parameter int RATIO   = 4
);
    localparam int BW_COUNT = $clog2(RATIO + 1);

    logic                       fifo_rready;
    logic                       fifo_rrequest;
    logic [BW_DATA-1:0]         fifo_rdata;
    logic                       out_valid;
    logic                       out_ready;
    logic [BW_DATA*RATIO-1:0]   out_data;
    logic [BW_COUNT-1:0]        out_count;
    logic                       flush;
    logic                       flush_busy;

    modport master (
        input  fifo_rready, fifo_rdata, out_ready, flush,
        output fifo_rrequest, out_valid, out_data, out_count, flush_busy
    );

    modport slave (
        output fifo_rready, fifo_rdata, out_ready, flush,
        input  fifo_rrequest, out_valid, out_data, out_count, flush_busy
    );
endinterface

// File: rtl/ervp_fifo_rd_packer.sv
// Purpose : pops narrow FIFO words and packs RATIO of them into one wide word,
//           first popped word in lane 0; optional flush of a partial word.
// Latency : the pop completing a word is visible on out_valid/out_data next cycle.
// Backpressure: only the completing pop stalls while the output register is
//           full and out_ready=0; non-completing pops keep filling the accumulator.
//
// Ports:
//   clk  read-domain clock (same as FIFO read side)
//   rst  synchronous active-high reset
//   bus  ervp_fifo_rd_packer_if.master (FIFO read port, output stream, flush)
// Optional feature: define ERVP_FIFO_RD_PACKER_FLUSH_EN to enable the flush
// logic; when undefined, flush is ignored and flush_busy is tied low.
module ervp_fifo_rd_packer #(
    parameter int BW_DATA = 8,
    parameter int RATIO   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ervp_fifo_rd_packer_if.master bus
);
    localparam int BW_COUNT = $clog2(RATIO + 1);
    localparam int BW_OUT   = BW_DATA * RATIO;
    localparam logic [BW_COUNT-1:0] LAST_LANE = BW_COUNT'(RATIO - 1);
    localparam logic [BW_COUNT-1:0] FULL_CNT  = BW_COUNT'(RATIO);

    logic [BW_COUNT-1:0] r_cnt;
    logic                r_out_valid;
    logic [BW_OUT-1:0]   r_out_data;
    logic [BW_COUNT-1:0] r_out_count;

    logic                w_slot_free;
    logic                w_last;
    logic                w_xfer;
    logic                w_pop;
    logic                w_flush_act;
    logic [BW_OUT-1:0]   w_full_word;

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_xfer      = r_out_valid && bus.out_ready;
    assign w_last      = (r_cnt == LAST_LANE);

`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
    logic              r_flush_pending;
    logic              w_flush_emit;
    logic [BW_OUT-1:0] w_partial;

    // A live flush (new request or pending) blocks pops, so flush wins over a
    // pop in the same cycle.
    assign w_flush_act  = bus.flush || r_flush_pending;
    assign w_flush_emit = w_flush_act && w_slot_free && (r_cnt != '0);

    // Pending only survives while the output register cannot take the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_pending <= 1'b0;
        end else if (w_flush_act) begin
            r_flush_pending <= !w_slot_free;
        end
    end

    assign bus.flush_busy = r_flush_pending;
`else
    assign w_flush_act    = 1'b0;
    assign bus.flush_busy = 1'b0;
`endif

    // The completing pop needs a free output slot; earlier lanes never do.
    assign w_pop = bus.fifo_rready && !w_flush_act && !(w_last && !w_slot_free);
    assign bus.fifo_rrequest = w_pop;

    generate
        if (RATIO > 1) begin : g_acc
            logic [(RATIO-1)*BW_DATA-1:0] r_acc;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_pop && !w_last) begin
                    for (int i = 0; i < RATIO - 1; i++) begin
                        if (r_cnt == BW_COUNT'(i)) begin
                            r_acc[i*BW_DATA +: BW_DATA] <= bus.fifo_rdata;
                        end
                    end
                end
            end

            assign w_full_word = {bus.fifo_rdata, r_acc};

`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
            // Stale lanes at or above cnt are masked so flushed words carry zeros.
            always_comb begin
                w_partial = '0;
                for (int i = 0; i < RATIO - 1; i++) begin
                    if (BW_COUNT'(i) < r_cnt) begin
                        w_partial[i*BW_DATA +: BW_DATA] = r_acc[i*BW_DATA +: BW_DATA];
                    end
                end
            end
`endif
        end else begin : g_noacc
            // Single-lane packing: every pop goes straight to the output register.
            assign w_full_word = bus.fifo_rdata;
`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
            assign w_partial = '0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_pop) begin
            r_cnt <= w_last ? '0 : r_cnt + BW_COUNT'(1);
`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
        end else if (w_flush_emit) begin
            r_cnt <= '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_pop && w_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_full_word;
            r_out_count <= FULL_CNT;
`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
        end else if (w_flush_emit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_partial;
            r_out_count <= r_cnt;
`endif
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_ervp_fifo_rd_packer.sv
// Purpose : self-checking bench for ervp_fifo_rd_packer with RATIO=4 and RATIO=1
//           instances driven side by side and checked against a lane-queue model.
// Latency : n/a (testbench).
// Backpressure: out_ready and fifo_rready are driven by the bench.
module tb_ervp_fifo_rd_packer;
`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
    localparam bit FLEN = 1'b1;
`else
    localparam bit FLEN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic       in_rr[2];
    logic [7:0] in_rd[2];
    logic       in_ordy[2];
    logic       in_fl[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ervp_fifo_rd_packer_if #(.BW_DATA(8), .RATIO(4)) if4 ();
    ervp_fifo_rd_packer_if #(.BW_DATA(8), .RATIO(1)) if1 ();

    assign if4.fifo_rready = in_rr[0];
    assign if4.fifo_rdata  = in_rd[0];
    assign if4.out_ready   = in_ordy[0];
    assign if4.flush       = in_fl[0];
    assign if1.fifo_rready = in_rr[1];
    assign if1.fifo_rdata  = in_rd[1];
    assign if1.out_ready   = in_ordy[1];
    assign if1.flush       = in_fl[1];

    ervp_fifo_rd_packer #(.BW_DATA(8), .RATIO(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    ervp_fifo_rd_packer #(.BW_DATA(8), .RATIO(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic        rreq_w[2];
    logic        ov_w[2];
    logic        fb_w[2];
    logic [31:0] od_w[2];
    logic [2:0]  oc_w[2];
    assign rreq_w[0] = if4.fifo_rrequest;
    assign rreq_w[1] = if1.fifo_rrequest;
    assign ov_w[0]   = if4.out_valid;
    assign ov_w[1]   = if1.out_valid;
    assign fb_w[0]   = if4.flush_busy;
    assign fb_w[1]   = if1.flush_busy;
    assign od_w[0]   = if4.out_data;
    assign od_w[1]   = {24'h0, if1.out_data};
    assign oc_w[0]   = if4.out_count;
    assign oc_w[1]   = {2'b0, if1.out_count};

    // Reference model: lanes waiting in the accumulator plus the output register.
    int          mcnt[2];
    logic [7:0]  macc[2][4];
    bit          mov[2];
    logic [31:0] mod[2];
    int          moc[2];
    bit          mfp[2];

    int total;
    int bad;
    bit seen_rreq[2];

    typedef struct packed {
        logic        rr;
        logic [7:0]  rd;
        logic        ordy;
        logic        e_rreq;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_oc;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(logic rr, logic [7:0] rd, logic ordy, logic er,
                                logic ev, logic [31:0] ed, logic [2:0] ec);
        vec_t v;
        v.rr = rr; v.rd = rd; v.ordy = ordy;
        v.e_rreq = er; v.e_ov = ev; v.e_od = ed; v.e_oc = ec;
        return v;
    endfunction

    function automatic int rat(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] pack(input int k, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = w | (32'(macc[k][i]) << (8 * i));
        return w;
    endfunction

    function automatic bit exp_pop(input int k);
        bit fl_act;
        bit blocked;
        fl_act  = FLEN && (in_fl[k] || mfp[k]);
        blocked = (mcnt[k] == rat(k) - 1) && mov[k] && !in_ordy[k];
        return in_rr[k] && !fl_act && !blocked;
    endfunction

    task automatic model_step(input int k);
        bit pop, slot, act, loaded;
        if (rst) begin
            mcnt[k] = 0; mov[k] = 0; mod[k] = '0; moc[k] = 0; mfp[k] = 0;
            for (int i = 0; i < 4; i++) macc[k][i] = '0;
            return;
        end
        pop    = exp_pop(k);
        slot   = !mov[k] || in_ordy[k];
        loaded = 0;
        if (pop) begin
            macc[k][mcnt[k]] = in_rd[k];
            mcnt[k]++;
            if (mcnt[k] == rat(k)) begin
                mod[k] = pack(k, rat(k)); moc[k] = rat(k); loaded = 1; mcnt[k] = 0;
            end
        end
        if (FLEN) begin
            act = in_fl[k] || mfp[k];
            if (act && slot) begin
                if (mcnt[k] > 0) begin
                    mod[k] = pack(k, mcnt[k]); moc[k] = mcnt[k]; loaded = 1; mcnt[k] = 0;
                end
                mfp[k] = 0;
            end else if (act) begin
                mfp[k] = 1;
            end
        end
        if (loaded) mov[k] = 1;
        else if (mov[k] && in_ordy[k]) mov[k] = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at the falling edge with new inputs already applied.
    task automatic tick();
        #1;
        for (int k = 0; k < 2; k++) begin
            seen_rreq[k] = rreq_w[k];
            if (!rst) chk($sformatf("rreq%0d", k), 32'(rreq_w[k]), 32'(exp_pop(k)));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(ov_w[k]), 32'(mov[k]));
            chk($sformatf("flush_busy%0d", k), 32'(fb_w[k]), 32'(mfp[k]));
            if (mov[k]) begin
                chk($sformatf("out_data%0d", k), od_w[k], mod[k]);
                chk($sformatf("out_count%0d", k), 32'(oc_w[k]), 32'(moc[k]));
            end
        end
    endtask

    task automatic set_in(input logic rr, input logic [7:0] rd, input logic ordy, input logic fl);
        for (int k = 0; k < 2; k++) begin
            in_rr[k] = rr; in_rd[k] = rd; in_ordy[k] = ordy; in_fl[k] = fl;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ov%0d", k), 32'(ov_w[k]), 32'd0);
            chk($sformatf("rst_od%0d", k), od_w[k], 32'd0);
            chk($sformatf("rst_oc%0d", k), 32'(oc_w[k]), 32'd0);
            chk($sformatf("rst_fb%0d", k), 32'(fb_w[k]), 32'd0);
        end
    endtask

    task automatic pop4(input logic [7:0] b0, input logic ordy);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, b0 + 8'(i), ordy, 1'b0);
            tick();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 1'b0);

        tbl[0]  = mk(1, 8'h01, 1, 1, 0, 32'h0, 3'd0);
        tbl[1]  = mk(1, 8'h02, 1, 1, 0, 32'h0, 3'd0);
        tbl[2]  = mk(1, 8'h03, 1, 1, 0, 32'h0, 3'd0);
        tbl[3]  = mk(1, 8'h04, 1, 1, 1, 32'h04030201, 3'd4);
        tbl[4]  = mk(1, 8'h05, 0, 1, 1, 32'h04030201, 3'd4);
        tbl[5]  = mk(1, 8'h06, 0, 1, 1, 32'h04030201, 3'd4);
        tbl[6]  = mk(1, 8'h07, 0, 1, 1, 32'h04030201, 3'd4);
        tbl[7]  = mk(1, 8'h08, 0, 0, 1, 32'h04030201, 3'd4);
        tbl[8]  = mk(1, 8'h08, 0, 0, 1, 32'h04030201, 3'd4);
        tbl[9]  = mk(1, 8'h08, 1, 1, 1, 32'h08070605, 3'd4);
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 32'h0, 3'd0);
        tbl[11] = mk(1, 8'h09, 1, 1, 0, 32'h0, 3'd0);
        tbl[12] = mk(1, 8'h0A, 1, 1, 0, 32'h0, 3'd0);
        tbl[13] = mk(1, 8'h0B, 1, 1, 0, 32'h0, 3'd0);
        tbl[14] = mk(1, 8'h0C, 1, 1, 1, 32'h0C0B0A09, 3'd4);
        tbl[15] = mk(1, 8'h0D, 1, 1, 0, 32'h0, 3'd0);
        tbl[16] = mk(1, 8'h0E, 1, 1, 0, 32'h0, 3'd0);
        tbl[17] = mk(1, 8'h0F, 1, 1, 0, 32'h0, 3'd0);
        tbl[18] = mk(1, 8'h10, 1, 1, 1, 32'h100F0E0D, 3'd4);

        @(negedge clk);
        do_reset();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        chk("rst_rreq", 32'(rreq_w[0]), 32'd0);

        // Stream and backpressure vectors on the RATIO=4 instance.
        for (int i = 0; i < 19; i++) begin
            set_in(tbl[i].rr, tbl[i].rd, tbl[i].ordy, 1'b0);
            tick();
            chk($sformatf("tbl%0d_rreq", i), 32'(seen_rreq[0]), 32'(tbl[i].e_rreq));
            chk($sformatf("tbl%0d_ov", i), 32'(ov_w[0]), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_od", i), od_w[0], tbl[i].e_od);
                chk($sformatf("tbl%0d_oc", i), 32'(oc_w[0]), 32'(tbl[i].e_oc));
            end
        end

        // Reset mid-operation: cnt=2 with a held output word.
        do_reset();
        pop4(8'h01, 1'b1);
        set_in(1'b1, 8'h05, 1'b0, 1'b0); tick();
        set_in(1'b1, 8'h06, 1'b0, 1'b0); tick();
        chk("pre_rst_ov", 32'(ov_w[0]), 32'd1);
        do_reset();
        pop4(8'hA1, 1'b1);
        chk("rst_lane0_ov", 32'(ov_w[0]), 32'd1);
        chk("rst_lane0_od", od_w[0], 32'hA4A3A2A1);

        // Single-lane instance passes each pop straight through.
        do_reset();
        set_in(1'b1, 8'h5A, 1'b1, 1'b0); tick();
        chk("r1_od", od_w[1], 32'h5A);
        chk("r1_oc", 32'(oc_w[1]), 32'd1);
        set_in(1'b1, 8'h3C, 1'b0, 1'b0); tick();
        chk("r1_stall_rreq", 32'(seen_rreq[1]), 32'd0);
        chk("r1_hold_od", od_w[1], 32'h5A);

`ifdef ERVP_FIFO_RD_PACKER_FLUSH_EN
        // Flush with an empty output register, then flush with nothing buffered.
        do_reset();
        set_in(1'b1, 8'hAA, 1'b1, 1'b0); tick();
        set_in(1'b1, 8'hBB, 1'b1, 1'b0); tick();
        set_in(1'b1, 8'hCC, 1'b1, 1'b1); tick();
        chk("fl_wins_rreq", 32'(seen_rreq[0]), 32'd0);
        chk("fl_ov", 32'(ov_w[0]), 32'd1);
        chk("fl_od", od_w[0], 32'h0000BBAA);
        chk("fl_oc", 32'(oc_w[0]), 32'd2);
        chk("fl_fb", 32'(fb_w[0]), 32'd0);
        set_in(1'b0, 8'h00, 1'b1, 1'b1); tick();
        chk("fl_empty_ov", 32'(ov_w[0]), 32'd0);
        chk("fl_empty_fb", 32'(fb_w[0]), 32'd0);

        // Flush under backpressure stays pending until the slot frees.
        do_reset();
        pop4(8'h01, 1'b1);
        set_in(1'b1, 8'h05, 1'b0, 1'b0); tick();
        set_in(1'b1, 8'h06, 1'b0, 1'b1); tick();
        chk("flbp_rreq0", 32'(seen_rreq[0]), 32'd0);
        chk("flbp_fb", 32'(fb_w[0]), 32'd1);
        set_in(1'b1, 8'h06, 1'b0, 1'b0); tick();
        chk("flbp_rreq1", 32'(seen_rreq[0]), 32'd0);
        set_in(1'b1, 8'h06, 1'b1, 1'b0); tick();
        chk("flbp_rreq2", 32'(seen_rreq[0]), 32'd0);
        chk("flbp_od", od_w[0], 32'h00000005);
        chk("flbp_oc", 32'(oc_w[0]), 32'd1);
        chk("flbp_fb_clr", 32'(fb_w[0]), 32'd0);
`else
        // Without the flush feature a flush request changes nothing.
        do_reset();
        set_in(1'b1, 8'hAA, 1'b1, 1'b0); tick();
        set_in(1'b1, 8'hBB, 1'b1, 1'b0); tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b1); tick();
        chk("nofl_ov", 32'(ov_w[0]), 32'd0);
        chk("nofl_fb", 32'(fb_w[0]), 32'd0);
        set_in(1'b1, 8'hCC, 1'b1, 1'b1); tick();
        chk("nofl_rreq", 32'(seen_rreq[0]), 32'd1);
        set_in(1'b1, 8'hDD, 1'b1, 1'b0); tick();
        chk("nofl_od", od_w[0], 32'hDDCCBBAA);
        chk("nofl_oc", 32'(oc_w[0]), 32'd4);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 127) == 0);
            for (int k = 0; k < 2; k++) begin
                in_rr[k]   = ($urandom_range(0, 3) != 0);
                in_rd[k]   = 8'($urandom);
                in_ordy[k] = ($urandom_range(0, 3) != 0);
                in_fl[k]   = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
